// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, scan state type and leading-zero test for the 7-segment scanner
package seg_pkg;
  localparam int SEG_DIGITS = 4;
  localparam logic [SEG_DIGITS-1:0] AN_OFF = 4'b1111;
  typedef enum logic {SHOW, BLANK} state_t;
  // digit k is a leading zero when it and every digit above it are zero and it carries no DP
  function automatic logic lz_dark(input logic [15:0] v, input logic [3:0] dp, input logic [1:0] k);
    return k != 2'd0 && (v >> {k, 2'b00}) == 16'd0 && !dp[k];
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: dwell/guard counter and SHOW/BLANK sequencer that walks the digit index
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance enable; counter, state and k freeze while low
//   k          : current digit index
//   state      : SHOW (digit lit) or BLANK (guard, all anodes off)
//   adv        : high on the edge where k advances
module scan_timer import seg_pkg::*; #(
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] k,
  output state_t     state,
  output logic       adv
);
  localparam int CW = $clog2((DWELL > GUARD ? DWELL : GUARD) + 1);
  logic [CW-1:0] cnt, lim;
  assign lim = state == SHOW ? CW'(DWELL - 1) : CW'(GUARD - 1);
  // with no guard the SHOW slot hands straight to the next digit
  assign adv = en && cnt == lim && (state == BLANK || GUARD == 0);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      k <= 2'd0;
      state <= SHOW;
    end else if (en) begin
      cnt <= cnt == lim ? '0 : cnt + 1'b1;
      if (cnt == lim) begin
        state <= state == SHOW && GUARD != 0 ? BLANK : SHOW;
        if (adv) k <= k + 2'd1;
      end
    end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 4-digit common-anode 7-segment scanner with frame-boundary double buffering
//   CLK, RST : clock, synchronous active-high reset
//   EN       : scan enable (dark and frozen when low)
//   LD, D, DP: load strobe, 16-bit value, per-digit decimal point request
//   LZ       : leading-zero suppression enable
//   N        : nibble of current digit to the hex decoder
//   AN       : active-low anodes
//   DPN      : active-low decimal point
//   FRAME    : pulse on the first lit cycle of digit 0 in each new frame
module seg_scan import seg_pkg::*; #(
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  LD,
  input  logic [15:0]           D,
  input  logic [3:0]            DP,
  input  logic                  LZ,
  output logic [3:0]            N,
  output logic [SEG_DIGITS-1:0] AN,
  output logic                  DPN,
  output logic                  FRAME
);
  logic [15:0] pv, sv;
  logic [3:0] pdp, sdp;
  logic pf, fresh, adv, wrap, lit;
  logic [1:0] k;
  state_t state;
  scan_timer #(.DWELL(DWELL), .GUARD(GUARD)) u_timer (
    .clk(CLK), .rst(RST), .en(EN), .k(k), .state(state), .adv(adv)
  );
  assign wrap = adv && k == 2'd3;
  assign lit = EN && state == SHOW && !(LZ && lz_dark(sv, sdp, k));
  always_ff @(posedge CLK)
    if (RST) begin
      pv <= '0;
      pdp <= '0;
      pf <= 1'b0;
      sv <= '0;
      sdp <= '0;
      fresh <= 1'b0;
      AN <= AN_OFF;
      N <= '0;
      DPN <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      if (LD) begin
        pv <= D;
        pdp <= DP;
      end
      pf <= !wrap && (LD || pf);
      // a load on the boundary edge itself bypasses the pending buffer
      if (wrap) begin
        sv <= LD ? D : pf ? pv : sv;
        sdp <= LD ? DP : pf ? pdp : sdp;
      end
      // fresh survives an EN-low stall so FRAME lands on the first lit digit-0 cycle
      fresh <= wrap || (fresh && !EN);
      FRAME <= EN && fresh;
      AN <= lit ? ~(SEG_DIGITS'(1) << k) : AN_OFF;
      DPN <= !(lit && sdp[k]);
      if (EN && state == SHOW) N <= sv[{k, 2'b00} +: 4];
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized and directed checks of seg_scan (GUARD=1 and GUARD=0) against a slot-arithmetic model
module tb_seg_scan;
  localparam int DW [2] = '{4, 4};
  localparam int GD [2] = '{1, 0};
  logic CLK = 0, RST = 1, EN = 0, LD = 0, LZ = 0;
  logic [15:0] D = 0;
  logic [3:0] DP = 0;
  logic [3:0] n_o [2];
  logic [3:0] an_o [2];
  logic dpn_o [2];
  logic fr_o [2];
  int vectors = 0, errors = 0;
  int p [2];
  logic [15:0] msv [2], mpv [2];
  logic [3:0] msdp [2], mpdp [2];
  logic mpf [2];
  logic [3:0] e_an [2], e_n [2];
  logic e_dpn [2], e_fr [2];

  always #5 CLK = ~CLK;

  seg_scan #(.DWELL(4), .GUARD(1)) u0 (.CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(D), .DP(DP), .LZ(LZ),
    .N(n_o[0]), .AN(an_o[0]), .DPN(dpn_o[0]), .FRAME(fr_o[0]));
  seg_scan #(.DWELL(4), .GUARD(0)) u1 (.CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(D), .DP(DP), .LZ(LZ),
    .N(n_o[1]), .AN(an_o[1]), .DPN(dpn_o[1]), .FRAME(fr_o[1]));

  // model: p counts enabled cycles since reset; digit and slot position follow by division
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      int sl, per, dg;
      bit bnd, lit;
      logic [15:0] hi;
      sl = DW[i] + GD[i];
      per = 4 * sl;
      dg = (p[i] / sl) % 4;
      bnd = 0;
      if (RST) begin
        p[i] = 0; msv[i] = 0; mpv[i] = 0; msdp[i] = 0; mpdp[i] = 0; mpf[i] = 0;
        e_an[i] = 4'hF; e_n[i] = 0; e_dpn[i] = 1; e_fr[i] = 0;
      end else begin
        e_fr[i] = EN && p[i] > 0 && p[i] % per == 0;
        if (EN) begin
          hi = msv[i] >> (4 * dg);
          lit = (p[i] % sl) < DW[i] && !(LZ && dg > 0 && hi == 0 && !msdp[i][dg]);
          e_an[i] = lit ? ~(4'b1 << dg) : 4'hF;
          e_dpn[i] = !(lit && msdp[i][dg]);
          if ((p[i] % sl) < DW[i]) e_n[i] = hi[3:0];
          bnd = (p[i] + 1) % per == 0;
          p[i]++;
        end else begin
          e_an[i] = 4'hF;
          e_dpn[i] = 1;
        end
        if (bnd) begin
          msv[i] = LD ? D : mpf[i] ? mpv[i] : msv[i];
          msdp[i] = LD ? DP : mpf[i] ? mpdp[i] : msdp[i];
          mpf[i] = 0;
        end else if (LD) mpf[i] = 1;
        if (LD) begin
          mpv[i] = D;
          mpdp[i] = DP;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL reset[%0d]: AN=%b N=%h DPN=%b FRAME=%b, want 1111 0 1 0", i, an_o[i], n_o[i], dpn_o[i], fr_o[i]);
        end
      end
    end
  endtask

  task automatic test_scan();
    int first [2] = '{-1, -1};
    RST = 0; EN = 1;
    for (int c = 0; c < 45; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL scan[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
        if (fr_o[i] && first[i] < 0) first[i] = c;
      end
      if (c == 0) begin
        vectors++;
        if (an_o[0] !== 4'b1110) begin
          errors++;
          $display("FAIL first_an: AN=%b, want 1110", an_o[0]);
        end
      end
    end
    vectors++;
    if (first[0] != 20 || first[1] != 16) begin
      errors++;
      $display("FAIL frame_cycle: got %0d/%0d, want 20/16", first[0], first[1]);
    end
  endtask

  task automatic test_load();
    for (int c = 0; c < 48; c++) begin
      LD = c == 7; D = 16'hBEEF; DP = 4'b0100;
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL load[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
    end
    LD = 0;
  endtask

  task automatic test_back_to_back();
    int c = 0;
    bit hit = 0;
    while (c < 60) begin
      hit = c > 4 && (p[0] + 1) % 20 == 0;
      LD = c == 1 || c == 3 || hit;
      D = hit ? 16'h9ABC : c == 1 ? 16'h1234 : 16'h5678;
      DP = hit ? 4'b0001 : 4'b0000;
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL b2b[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
      c++;
      if (hit) break;
    end
    LD = 0;
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL b2b_boundary: boundary not reached in %0d cycles", c);
    end
    repeat (45) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL b2b_after[%0d]: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
    end
  endtask

  task automatic test_lz();
    LZ = 1;
    for (int c = 0; c < 90; c++) begin
      LD = c == 0 || c == 45; D = c == 0 ? 16'h0070 : 16'h0000; DP = 0;
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL lz[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
    end
    LD = 0; LZ = 0;
  endtask

  task automatic test_enable();
    int c = 0;
    LD = 1; D = 16'h4321; DP = 4'b1010;
    step();
    LD = 0;
    while (c < 80) begin
      if (c < 40 && p[0] % 5 == 1 && (p[0] / 5) % 4 == 2) EN = 0;
      if (!EN && c >= 10 && p[0] % 5 == 1 && (p[0] / 5) % 4 == 2 && c > 0) begin
      end
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL enable[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
      if (!EN) begin
        vectors++;
        if (an_o[0] !== 4'hF || fr_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL enable_dark: AN=%b FRAME=%b, want 1111 0", an_o[0], fr_o[0]);
        end
        repeat (9) begin
          step();
          vectors++;
          if (an_o[0] !== 4'hF || an_o[1] !== 4'hF) begin
            errors++;
            $display("FAIL enable_dark: AN=%b/%b, want 1111", an_o[0], an_o[1]);
          end
        end
        EN = 1;
        c = 40;
      end
      c++;
    end
    EN = 1;
  endtask

  task automatic test_reset_mid();
    int c = 0;
    LD = 1; D = 16'h7E57; DP = 4'b0011;
    step();
    LD = 0;
    while (c < 20 && p[0] % 5 != 4) begin
      step();
      c++;
    end
    RST = 1; LD = 1; D = 16'hFFFF; DP = 4'hF;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: AN=%b N=%h DPN=%b FRAME=%b, want 1111 0 1 0", i, an_o[i], n_o[i], dpn_o[i], fr_o[i]);
      end
    end
    RST = 0; LD = 0;
    repeat (45) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL reset_after[%0d]: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      EN = $urandom % 8 != 0;
      LD = $urandom % 12 == 0;
      D = 16'($urandom);
      DP = $urandom % 3 == 0 ? 4'($urandom) : 4'h0;
      if (c % 60 == 0) LZ = 1'($urandom);
      RST = $urandom % 200 == 0;
      if ($urandom % 4 == 0) D = D & 16'h00FF;
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({an_o[i], n_o[i], dpn_o[i], fr_o[i]} !== {e_an[i], e_n[i], e_dpn[i], e_fr[i]}) begin
          errors++;
          $display("FAIL random[%0d] c%0d: AN=%b N=%h DPN=%b FR=%b, want %b %h %b %b", i, c, an_o[i], n_o[i], dpn_o[i], fr_o[i], e_an[i], e_n[i], e_dpn[i], e_fr[i]);
        end
      end
    end
    RST = 0; EN = 1; LD = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_lz();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scanner for a 4-digit common-anode 7-segment display. It holds a 16-bit value and walks the digits one at a time. For each digit it presents that digit's 4-bit nibble to the downstream hex-to-segment decoder, drives the active-low anode for that digit, and drives the decimal point. Between digits it inserts a guard interval with all anodes off to suppress ghosting. Values loaded mid-frame are double-buffered and take effect only at a frame boundary, so a displayed number never tears.

## Interface
- `DWELL`, default 50000: clock cycles each digit is lit; minimum 1.
- `GUARD`, default 500: clock cycles with all anodes off between digits; 0 disables the guard interval.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EN`  in  1  scan enable; when low, the display is dark and scan state is frozen.
- `LD`  in  1  load strobe; captures `D` and `DP` into the pending buffer.
- `D`  in  16  value to display; `D[3:0]` is digit 0 (rightmost).
- `DP`  in  4  decimal-point request per digit, active-high.
- `LZ`  in  1  leading-zero suppression enable.
- `N`  out  4  nibble of the current digit, sent to the hex-to-segment decoder.
- `AN`  out  4  digit anodes, active-low, at most one low at a time.
- `DPN`  out  1  decimal-point segment, active-low.
- `FRAME`  out  1  one-cycle pulse at the first lit cycle of digit 0 in each new frame.

## Operation
- Registers:
  - pending value and DP (`PV`, `PDP`) plus a pending flag `PF`;
  - display value and DP (`SV`, `SDP`);
  - digit index `K` (2 bits);
  - dwell counter, width `$clog2(max(DWELL,GUARD)+1)`;
  - state, one of `SHOW` or `BLANK`.
- `LD`=1: `PV`←`D`, `PDP`←`DP`, `PF`←1. A later `LD` before the frame boundary overwrites the pending buffer; last write wins.
- Frame boundary: the edge on which `K` advances from 3 to 0.
  - If `PF`=1, then `SV`←`PV`, `SDP`←`PDP`, `PF`←0.
  - If `LD` is asserted on that same edge, `D`/`DP` go directly to `SV`/`SDP` and `PF` ends at 0.
- `SHOW` state:
  - `AN`=~(1<<`K`), `N`=`SV[4K+3:4K]`, `DPN`=~`SDP[K]`.
  - The counter runs 0..`DWELL`−1.
  - At `DWELL`−1, the next state is `BLANK` (if `GUARD`>0) or `SHOW` with `K`+1 (if `GUARD`=0).
- `BLANK` state:
  - `AN`=4'b1111 and `DPN`=1; `N` holds its last value.
  - The counter runs 0..`GUARD`−1, then the next state is `SHOW` with `K`+1 (mod 4). The counter clears on every state change.
- Leading-zero suppression (`LZ`=1):
  - Digit k>0 is dark (`AN[k]`=1, `DPN`=1) when `SV[15:4k]`==0 and `SDP[k]`=0.
  - Digit 0 is never suppressed.
  - A suppressed digit still consumes its full `DWELL` slot, so the frame period stays constant.
- `EN`=0:
  - `AN`=4'b1111, `DPN`=1, and `FRAME`=0.
  - Counter, state and `K` hold their values; scanning resumes from the same point when `EN` returns to 1.
  - `LD` still captures into the pending buffer.
  - A frame boundary cannot occur while scanning is frozen, so no `SV` update happens.

## Timing
- Reset values:
  - `AN`=4'b1111, `N`=0, `DPN`=1, `FRAME`=0.
  - `SV`=0, `SDP`=0, `PV`=0, `PDP`=0, `PF`=0.
  - `K`=0, state=`SHOW`, counter=0.
- All outputs are registered. `AN`, `N` and `DPN` change on the same edge, so there is no skew between the nibble and its anode.
- First cycle after `RST` deasserts (with `EN`=1): `AN`=4'b1110. `FRAME` does not pulse for this first partial frame.
- Frame period is 4·(`DWELL`+`GUARD`) cycles. `FRAME` is high on the same cycle that `AN` first shows 4'b1110 with the newly swapped `SV`.
- Load latency: a value loaded by `LD` appears on `N` at the start of the next frame, at most 4·(`DWELL`+`GUARD`) cycles later.
- `RST` asserted mid-frame: on the next edge every register returns to its reset value and any pending load is discarded.
- `LD` asserted together with `RST`: reset wins.

## Structure
- Shared package `seg_pkg`:
  - constant `SEG_DIGITS`=4;
  - constant `AN_OFF`=4'b1111;
  - state enum {`SHOW`, `BLANK`}.
- Sub-module `scan_timer`:
  - parameterized dwell/guard counter and state machine;
  - outputs: `K`, state, and an advance pulse.
- The segment decoder is instantiated beside `seg_scan` at board top level, taking `N` as its input. `DPN` routes to the decimal-point pin separately.

## Test plan
All scenarios use `DWELL`=4, `GUARD`=1 unless stated.

1. Reset, then `EN`=1 with no load: `AN` sequence 1110×4, 1111×1, 1101×4, 1111×1, 1011×4, 1111×1, 0111×4, 1111×1, repeating with `N`=0 throughout; `FRAME` pulses at cycle 20.
2. `LD` with `D`=16'hBEEF, `DP`=4'b0100 mid-frame: the old value continues to the boundary. The next frame shows `N`=F,E,E,B for `K`=0..3, with `DPN`=0 only while `AN`=1011.
3. Two loads in one frame (16'h1234, then 16'h5678); then `LD` with 16'h9ABC on the exact boundary edge: the frame after the first boundary shows 5678; 9ABC is shown from the boundary where it was loaded.
4. `LZ`=1, `D`=16'h0070, `DP`=0: digits 3 and 2 are dark in their slots; digit 1 shows 7 and digit 0 shows 0; period stays 20 cycles. With `D`=0, only digit 0 lights.
5. `EN` low for 10 cycles during digit 2's slot: `AN`=1111 throughout. After re-enable, digit 2 lights for exactly its remaining cycles; `FRAME` is delayed by 10 cycles.
6. `RST` pulsed during a `BLANK` with `PF`=1: all outputs go to reset values, and the pending value never appears on `N`. `GUARD`=0 variant: no 1111 cycles between digits.
